mop_accum_ctrl: RTL

MOP_ACCUM_CTRL -- requirements
Module: mop_accum_ctrl

---
 rtl/mop_accum_ctrl_if.sv | 28 ++
 rtl/mop_accum_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/mop_accum_ctrl_if.sv
// Job/operand/result bundle for the multi-operand accumulator controller.
// Every valid/ready pair transfers on a rising edge where both are high; ready never looks at valid.
interface mop_accum_ctrl_if #(
  parameter int SUM_W = 12
);
  logic             start;
  logic [4:0]       num_ops;
  logic             abort;
  logic             op_valid;
  logic [7:0]       op_data;
  logic             op_ready;
  logic [SUM_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             busy;
  logic             err;
  logic [1:0]       state_dbg;

  modport master (
    output start, num_ops, abort, op_valid, op_data, sum_ready,
    input  op_ready, sum, sum_valid, busy, err, state_dbg
  );

  modport slave (
    input  start, num_ops, abort, op_valid, op_data, sum_ready,
    output op_ready, sum, sum_valid, busy, err, state_dbg
  );
endinterface

// File: rtl/mop_accum_ctrl.sv
// Accumulates num_ops unsigned bytes through a single 8-bit adder; the carry-out
// bumps the upper accumulator bits in the same cycle.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {8'b0, ci};
endmodule

module mop_accum_ctrl #(
    parameter int MAX_OPS = 8,
    parameter int SUM_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    mop_accum_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] MAX_OPS_W = 5'(MAX_OPS);

    state_t           state, state_nx;
    logic [SUM_W-1:0] acc;
    logic [4:0]       count;
    logic             err_q;
    logic             load;
    logic             err_nx;
    logic             xfer;
    logic             legal;
    logic [7:0]       add_s;
    logic             add_co;

    adder8 u_adder8 (
        .a  (acc[7:0]),
        .b  (bus.op_data),
        .ci (1'b0),
        .s  (add_s),
        .co (add_co)
    );

    // abort gates ready so an aborted cycle can never also transfer an operand
    assign bus.op_ready  = (state == ACCUM) && !bus.abort;
    assign xfer          = bus.op_valid && bus.op_ready;
    assign legal         = (bus.num_ops != 5'd0) && (bus.num_ops <= MAX_OPS_W);
    assign bus.sum       = acc;
    assign bus.sum_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err_q;
    assign bus.state_dbg = state;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (legal) begin
                        state_nx = ACCUM;
                        load     = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (bus.abort)
                    state_nx = IDLE;
                else if (xfer && (count == 5'd1))
                    state_nx = DONE;
            end
            DONE: begin
                if (bus.sum_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (load) begin
                acc   <= '0;
                count <= bus.num_ops;
            end else if (xfer) begin
                acc[7:0]       <= add_s;
                acc[SUM_W-1:8] <= acc[SUM_W-1:8] + (SUM_W-8)'(add_co);
                count          <= count - 5'd1;
            end
        end
    end
endmodule
